bayer_mosaic_reader: RTL and testbench
======================================

BAYER_MOSAIC_READER -- requirements
Module: bayer_mosaic_reader

Interface
REQ-001 Parameter IMG_LOG2, default 7, meaning log2 of image width and height (128x128 frame).
REQ-002 Parameter DW, default 8, meaning pixel width in bits.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to stream one frame; sampled only in IDLE.
REQ-006 addr_r, addr_g, addr_b  output  14 each  registered read addresses into the R, G and B plane memories ({row, col}).
REQ-007 rdata_r, rdata_g, rdata_b  input  8 each  plane read data, a combinational function of the current addr_*.
REQ-008 out_valid  output  1  out_data holds a valid mosaic pixel.
REQ-009 out_data  output  8  mosaic pixel, raster order.
REQ-010 out_last  output  1  qualifies the beat carrying pixel 16383.
REQ-011 out_ready  input  1  sink accepts the beat when out_valid && out_ready.
REQ-012 busy  output  1  high in READ and DRAIN.
REQ-013 done  output  1  one-cycle pulse at frame completion.

Function
REQ-014 FSM states: IDLE, READ, DRAIN, DONE. IDLE->READ on start. READ->DRAIN when pixel 16383 is pushed. DRAIN->DONE when the last beat handshakes. DONE->IDLE unconditionally after one cycle.
REQ-015 Entry to READ sets the pixel counter to 0. addr_r, addr_g and addr_b are all driven with the counter value.
REQ-016 Colour selection by {row[0], col[0]} of the counter: 00=G, 01=R, 10=B, 11=G (GRBG). The pushed pixel is the rdata of the selected plane.
REQ-017 Output buffering uses a 2-entry FIFO.
REQ-018 In READ, a push occurs when the FIFO count is below 2, or when it equals 2 and a pop occurs in the same cycle. A push increments the counter; no push means the counter and addresses hold.
REQ-019 Simultaneous push and pop leaves the count unchanged and preserves order.
REQ-020 out_valid equals FIFO not empty. out_data and out_last come from the FIFO head.
REQ-021 While out_valid && !out_ready, out_data and out_last shall hold stable.
REQ-022 out_last is stored with the pixel whose counter value is 16383. It is never asserted on any other beat.
REQ-023 Latency: with start high in cycle 0, pixel 0 is valid in cycle 2. With out_ready held at 1, one beat is produced per cycle and done is high in cycle 16386.
REQ-024 Counter wrap: the counter never increments past 16383 within a frame. In DRAIN and DONE the addresses hold at 16383.
REQ-025 start is ignored in READ, DRAIN and DONE. It does not queue.
REQ-026 Any pixel already in the FIFO at a DRAIN exit is a protocol error. DONE is entered only when the FIFO is empty.
REQ-027 done is registered and is high exactly in the DONE cycle. busy is low in IDLE and DONE.

Reset
REQ-028 reset forces IDLE, counter 0 and FIFO empty.
REQ-029 Reset values: addr_* = 0, out_valid = 0, out_data = 0, out_last = 0, busy = 0, done = 0.
REQ-030 A reset mid-frame discards all buffered pixels. The next start restarts at pixel 0.

Structure
REQ-031 A shared package holds IMG_LOG2, the address-width constant (2*IMG_LOG2), the FSM state enum, the colour-select enum (COL_R, COL_G, COL_B) and the GRBG select function. The demosaic side uses the same select function.
REQ-032 One sub-module, pix_fifo2: a 2-entry FIFO of width DW+1 (data plus last), with count, push, pop and asynchronous reset.

Verification
REQ-033 Constant planes R=0x11, G=0x22, B=0x33, out_ready=1, start pulse in cycle 0:
- row 0 streams 22,11,22,11,...
- row 1 streams 33,22,33,22,...
- exactly 16384 beats, out_last on beat 16383 only, done high in cycle 16386 only.
REQ-034 Address-coded planes (R=addr[7:0], G=addr[7:0]^0x55, B=addr[7:0]^0xAA):
- beat k equals the GRBG-selected formula for k, for all k.
REQ-035 out_ready low for 10 cycles starting at beat 100:
- out_data and out_last stable, addresses stall at most 2 ahead.
- no pixel lost or duplicated, done delayed by exactly 10 cycles.
REQ-036 Random out_ready (50%):
- beat sequence identical to REQ-034.
- busy high from cycle 1 until DONE.
REQ-037 start pulses during READ, DRAIN and DONE:
- no effect, a single frame of 16384 beats.
REQ-038 Reset asserted after beat 500, then start:
- outputs 0 during reset.
- first beat after restart is pixel 0 (G of address 0).

Source files
------------

// File: rtl/bayer_mosaic_reader_pkg.sv
// Shared definitions for the Bayer mosaic reader and the matching demosaic side:
// frame geometry, FSM states and the GRBG colour-select function.
package bayer_mosaic_reader_pkg;

    localparam int IMG_LOG2 = 7;
    localparam int ADDR_W   = 2 * IMG_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        COL_R,
        COL_G,
        COL_B
    } col_sel_e;

    // GRBG tile: even rows G R G R ..., odd rows B G B G ...
    function automatic col_sel_e grbg_sel(input logic row0, input logic col0);
        col_sel_e sel;
        case ({row0, col0})
            2'b01:   sel = COL_R;
            2'b10:   sel = COL_B;
            default: sel = COL_G;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/bayer_mosaic_reader_pix_fifo2.sv
// Two-entry FIFO carrying a pixel plus its end-of-frame flag.
// Push while full is accepted only when a pop frees the head slot in the same cycle.
module pix_fifo2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   count,
    output logic         not_empty
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push_ok, pop_ok;

    always_comb begin
        pop_ok   = pop && (count_q != 2'd0);
        push_ok  = push && ((count_q != 2'd2) || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 2'd1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign not_empty = (count_q != 2'd0);

endmodule

// File: rtl/bayer_mosaic_reader.sv
// Streams one frame from separate R/G/B planes as a GRBG mosaic in raster order,
// with a 2-deep output buffer so the sink can stall without losing pixels.
module bayer_mosaic_reader #(
    parameter int IMG_LOG2 = bayer_mosaic_reader_pkg::IMG_LOG2,
    parameter int DW       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [2*IMG_LOG2-1:0] addr_r,
    output logic [2*IMG_LOG2-1:0] addr_g,
    output logic [2*IMG_LOG2-1:0] addr_b,
    input  logic [DW-1:0]         rdata_r,
    input  logic [DW-1:0]         rdata_g,
    input  logic [DW-1:0]         rdata_b,
    output logic                  out_valid,
    output logic [DW-1:0]         out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);
    import bayer_mosaic_reader_pkg::*;

    localparam int AW = 2 * IMG_LOG2;
    localparam logic [AW-1:0] CNT_MAX = '1;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          push, pop;
    logic [DW-1:0] pix;
    logic [DW:0]   push_data, head_data;
    logic [1:0]    fifo_count;
    logic          fifo_ne;

    always_comb begin
        case (grbg_sel(cnt_q[IMG_LOG2], cnt_q[0]))
            COL_R:   pix = rdata_r;
            COL_B:   pix = rdata_b;
            default: pix = rdata_g;
        endcase
    end

    assign push_data = {(cnt_q == CNT_MAX), pix};
    assign pop       = fifo_ne && out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                end
            end
            ST_READ: begin
                if ((fifo_count < 2'd2) || pop) begin
                    push = 1'b1;
                    // Counter parks on the last pixel so addresses hold through DRAIN/DONE.
                    if (cnt_q == CNT_MAX) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && head_data[DW]) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_READ) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    pix_fifo2 #(.W(DW + 1)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (fifo_count),
        .not_empty (fifo_ne)
    );

    assign addr_r    = cnt_q;
    assign addr_g    = cnt_q;
    assign addr_b    = cnt_q;
    assign out_valid = fifo_ne;
    assign out_data  = head_data[DW-1:0];
    assign out_last  = head_data[DW];
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bayer_mosaic_reader.sv
// Scoreboard bench for bayer_mosaic_reader: expected beats are queued per frame,
// a negedge monitor pops and compares every accepted beat.
module tb_bayer_mosaic_reader;

    localparam int N = 16384;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        out_ready = 1'b1;
    logic [13:0] addr_r, addr_g, addr_b;
    logic [7:0]  rdata_r, rdata_g, rdata_b;
    logic        out_valid, out_last, busy, done;
    logic [7:0]  out_data;

    int          cyc = 0;
    int          mode = 0;
    int          beats = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    logic [8:0]  sb_q[$];
    logic [7:0]  cap [N];

    bayer_mosaic_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .addr_r    (addr_r),
        .addr_g    (addr_g),
        .addr_b    (addr_b),
        .rdata_r   (rdata_r),
        .rdata_g   (rdata_g),
        .rdata_b   (rdata_b),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rdata_r = (mode == 1) ? addr_r[7:0]          : 8'h11;
    assign rdata_g = (mode == 1) ? (addr_g[7:0] ^ 8'h55) : 8'h22;
    assign rdata_b = (mode == 1) ? (addr_b[7:0] ^ 8'hAA) : 8'h33;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int k, input int m);
        int row0, col0;
        logic [7:0] a, r, g, b;
        row0 = (k >> 7) & 1;
        col0 = k & 1;
        a = k[7:0];
        if (m == 0) begin
            r = 8'h11; g = 8'h22; b = 8'h33;
        end else begin
            r = a; g = a ^ 8'h55; b = a ^ 8'hAA;
        end
        if (row0 == col0) return g;
        else if (col0 == 1) return r;
        else return b;
    endfunction

    task automatic fill_sb(input int m);
        sb_q.delete();
        for (int k = 0; k < N; k++) sb_q.push_back({(k == N - 1), exp_pix(k, m)});
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_beat: got 0x%0h, expected no beat", {out_last, out_data});
            end else begin
                chk("beat", int'({out_last, out_data}), int'(sb_q.pop_front()));
            end
            if (beats < N) cap[beats] = out_data;
            beats++;
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_addr_r", int'(addr_r), 0);
        chk("rst_addr_g", int'(addr_g), 0);
        chk("rst_addr_b", int'(addr_b), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
    endtask

    // rmode: 0 ready always, 1 ten-cycle stall at beat 100 plus stray start pulses, 2 random ready
    task automatic run_frame(input int m, input int rmode, input int exp_done);
        int c0, rel, done_cnt, done_rel;
        logic [8:0] held;
        done_cnt = 0;
        done_rel = -1;
        held = '0;
        mode = m;
        beats = 0;
        fill_sb(m);
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            rel = cyc - c0;
            if (rel == 0) chk("busy_idle_c0", int'(busy), 0);
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) done_rel = rel;
                chk("busy_low_in_done", int'(busy), 0);
            end else if (rel >= 1 && done_cnt == 0) begin
                chk("busy_high", int'(busy), 1);
            end
            if (rmode == 1 && rel >= 102 && rel < 112) begin
                if (rel == 102) held = {out_last, out_data};
                else chk("stall_hold", int'({out_last, out_data}), int'(held));
                chk("stall_valid", int'(out_valid), 1);
                chk("addr_ahead_le2", int'((int'(addr_r) - beats) <= 2), 1);
            end
            if (done_cnt > 0 && rel >= done_rel + 3) break;
            @(posedge clk); #1;
            rel = cyc - c0;
            start = (rmode == 1) && (rel == 50 || rel == 16395 || rel == 16396);
            case (rmode)
                1:       out_ready = !(rel >= 102 && rel < 112);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
        start = 1'b0;
        chk("done_pulse_count", done_cnt, 1);
        if (exp_done >= 0) chk("done_cycle", done_rel, exp_done);
        chk("beat_count", beats, N);
        chk("sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        int guard;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;
        reset = 1'b0;

        // constant planes
        run_frame(0, 0, 16386);
        chk("c_beat0", int'(cap[0]), 'h22);
        chk("c_beat1", int'(cap[1]), 'h11);
        chk("c_beat2", int'(cap[2]), 'h22);
        chk("c_beat127", int'(cap[127]), 'h11);
        chk("c_beat128", int'(cap[128]), 'h33);
        chk("c_beat129", int'(cap[129]), 'h22);
        chk("c_beat16383", int'(cap[16383]), 'h22);

        // address-coded planes, sink stall and stray start pulses
        run_frame(1, 1, 16396);
        repeat (20) @(negedge clk);
        chk("no_second_frame_valid", int'(out_valid), 0);
        chk("no_second_frame_busy", int'(busy), 0);
        chk("a_beat0", int'(cap[0]), 'h55);
        chk("a_beat1", int'(cap[1]), 'h01);
        chk("a_beat128", int'(cap[128]), 'h2A);
        chk("a_beat129", int'(cap[129]), 'hD4);
        chk("a_beat255", int'(cap[255]), 'hAA);
        chk("a_beat16383", int'(cap[16383]), 'hAA);

        // random backpressure
        run_frame(1, 2, -1);
        chk("r_beat100", int'(cap[100]), 'h31);

        // mid-frame reset then restart
        @(posedge clk); #1;
        out_ready = 1'b1;
        mode = 1;
        beats = 0;
        fill_sb(1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (beats < 501 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("reached_beat_500", int'(beats >= 501), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        sb_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        beats = 0;
        fill_sb(1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (beats < 4 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("restart_beats", int'(beats >= 4), 1);
        chk("restart_beat0", int'(cap[0]), 'h55);
        chk("restart_beat1", int'(cap[1]), 'h01);
        @(posedge clk); #1;
        reset = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
